// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main controller.
//   - Opcode/funct encodings (OP_*, F_*). They are guarded so that an
//     earlier include of the shared cpu.svh header takes precedence.
//   - state_t: controller state encoding, also visible on state_o.
//   - ALUSrcB / PCSrc / ALUop select encodings.
//   - Helpers: funct legality and memory-access state classification.
`ifndef CPU_SVH
`define CPU_SVH
`define OP_RTYPE 6'h00
`define OP_J     6'h02
`define OP_BEQ   6'h04
`define OP_ADDI  6'h08
`define OP_SLTI  6'h0A
`define OP_ANDI  6'h0C
`define OP_ORI   6'h0D
`define OP_XORI  6'h0E
`define OP_LW    6'h23
`define OP_SW    6'h2B
`define F_SLL    6'h00
`define F_SRL    6'h02
`define F_SRA    6'h03
`define F_JR     6'h08
`define F_ADD    6'h20
`define F_SUB    6'h22
`define F_AND    6'h24
`define F_OR     6'h25
`define F_XOR    6'h26
`define F_NOR    6'h27
`define F_SLT    6'h2A
`endif

package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        IEXEC    = 4'd9,
        IWB      = 4'd10,
        JUMP     = 4'd11,
        JR       = 4'd12
    } state_t;

    localparam logic [1:0] ALUSRCB_RT      = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_RS     = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    function automatic logic is_legal_funct(input logic [5:0] f);
        return f inside {`F_SLL, `F_SRL, `F_SRA, `F_JR, `F_ADD, `F_SUB,
                         `F_AND, `F_OR, `F_XOR, `F_NOR, `F_SLT};
    endfunction

    // States that touch memory and therefore honour the wait counter.
    function automatic logic is_mem_state(input state_t s);
        return s inside {FETCH, MEMREAD, MEMWRITE};
    endfunction

endpackage

// File: rtl/main_control_fsm_mem_wait_counter.sv
// Memory wait down-counter.
//   clk   : system clock, rising edge
//   rst   : synchronous active-high reset, reloads MEM_LAT
//   load  : reload MEM_LAT (takes priority over count)
//   count : decrement while nonzero
//   zero  : counter has reached 0 (final cycle of a memory state)
module mem_wait_counter #(
    parameter int unsigned MEM_LAT = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic count,
    output logic zero
);

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LAT;
        end else if (count && (cnt_q != '0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= LAT;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/main_control_fsm.sv
// Multicycle MIPS main controller (Moore FSM).
//   clk, rst            : clock and synchronous active-high reset
//   opcode, funct       : instruction fields from the IR
//   IorD .. Branch      : datapath selects, write enables, ALUop/PC control
//   illegal_op          : one-cycle pulse in DECODE on an unrecognised instr
//   state_o             : current state encoding for debug
module main_control_fsm
    import ctrl_pkg::*;
#(
    parameter int unsigned MEM_LAT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUop,
    output logic [1:0] PCSrc,
    output logic       PCWrite,
    output logic       Branch,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    state_t state_q, state_d;
    logic   cnt_zero;
    logic   cnt_load;
    logic   illegal_d;
    logic   ir_we, pc_we, mem_we, reg_we;
    logic   en_ok;

    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        case (state_q)
            FETCH:    if (cnt_zero) state_d = DECODE;
            DECODE: begin
                case (opcode)
                    `OP_LW, `OP_SW: state_d = MEMADR;
                    `OP_RTYPE: begin
                        if (!is_legal_funct(funct)) begin
                            state_d   = FETCH;
                            illegal_d = 1'b1;
                        end else if (funct == `F_JR) begin
                            state_d = JR;
                        end else begin
                            state_d = EXECUTE;
                        end
                    end
                    `OP_BEQ: state_d = BRANCH;
                    `OP_ADDI, `OP_ANDI, `OP_ORI, `OP_XORI, `OP_SLTI: state_d = IEXEC;
                    `OP_J:   state_d = JUMP;
                    default: begin
                        state_d   = FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                if (opcode == `OP_LW)      state_d = MEMREAD;
                else if (opcode == `OP_SW) state_d = MEMWRITE;
                else                       state_d = FETCH;
            end
            MEMREAD:  if (cnt_zero) state_d = MEMWB;
            MEMWRITE: if (cnt_zero) state_d = FETCH;
            EXECUTE:  state_d = ALUWB;
            IEXEC:    state_d = IWB;
            MEMWB, ALUWB, BRANCH, IWB, JUMP, JR: state_d = FETCH;
            default:  state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Reload only on entry; a memory state holding on itself keeps counting.
    assign cnt_load = (state_d != state_q) && is_mem_state(state_d);

    mem_wait_counter #(.MEM_LAT(MEM_LAT)) u_wait (
        .clk   (clk),
        .rst   (rst),
        .load  (cnt_load),
        .count (is_mem_state(state_q)),
        .zero  (cnt_zero)
    );

    always_comb begin
        IorD     = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = ALUSRCB_RT;
        ALUop    = ALUOP_ADD;
        PCSrc    = PCSRC_ALU;
        Branch   = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        mem_we   = 1'b0;
        reg_we   = 1'b0;
        case (state_q)
            FETCH: begin
                ALUSrcB = ALUSRCB_FOUR;
                ir_we   = 1'b1;
                pc_we   = 1'b1;
            end
            DECODE:   ALUSrcB = ALUSRCB_IMM_SH2;
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = ALUSRCB_IMM;
            end
            MEMREAD:  IorD = 1'b1;
            MEMWB: begin
                MemtoReg = 1'b1;
                reg_we   = 1'b1;
            end
            MEMWRITE: begin
                IorD   = 1'b1;
                mem_we = 1'b1;
            end
            EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUop   = ALUOP_FUNCT;
            end
            ALUWB: begin
                RegDst = 1'b1;
                reg_we = 1'b1;
            end
            BRANCH: begin
                ALUSrcA = 1'b1;
                ALUop   = ALUOP_SUB;
                PCSrc   = PCSRC_ALUOUT;
                Branch  = 1'b1;
            end
            IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = ALUSRCB_IMM;
            end
            IWB:      reg_we = 1'b1;
            JUMP: begin
                PCSrc = PCSRC_JUMP;
                pc_we = 1'b1;
            end
            JR: begin
                PCSrc = PCSRC_RS;
                pc_we = 1'b1;
            end
            default: ;
        endcase
    end

    // Enables fire only in the last wait cycle, and never while reset is
    // held, so a mid-wait reset cannot commit a write.
    assign en_ok      = cnt_zero && !rst;
    assign IRWrite    = ir_we  && en_ok;
    assign PCWrite    = pc_we  && en_ok;
    assign MemWrite   = mem_we && en_ok;
    assign RegWrite   = reg_we && en_ok;
    assign illegal_op = (state_q == DECODE) && illegal_d && !rst;
    assign state_o    = state_q;

endmodule

// File: tb/tb_main_control_fsm.sv
module tb_main_control_fsm;

    localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4,
                   MEMWRITE = 5, EXECUTE = 6, ALUWB = 7, BRANCH = 8, IEXEC = 9,
                   IWB = 10, JUMP = 11, JR = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, rst2;
    logic [5:0] opc0, fn0, opc2, fn2;

    logic       IorD0, MemWrite0, IRWrite0, RegDst0, MemtoReg0, RegWrite0, ALUSrcA0;
    logic [1:0] ALUSrcB0, ALUop0, PCSrc0;
    logic       PCWrite0, Branch0, ill0;
    logic [3:0] st0;
    logic       IorD2, MemWrite2, IRWrite2, RegDst2, MemtoReg2, RegWrite2, ALUSrcA2;
    logic [1:0] ALUSrcB2, ALUop2, PCSrc2;
    logic       PCWrite2, Branch2, ill2;
    logic [3:0] st2;

    main_control_fsm #(.MEM_LAT(0)) dut0 (
        .clk(clk), .rst(rst0), .opcode(opc0), .funct(fn0),
        .IorD(IorD0), .MemWrite(MemWrite0), .IRWrite(IRWrite0), .RegDst(RegDst0),
        .MemtoReg(MemtoReg0), .RegWrite(RegWrite0), .ALUSrcA(ALUSrcA0),
        .ALUSrcB(ALUSrcB0), .ALUop(ALUop0), .PCSrc(PCSrc0), .PCWrite(PCWrite0),
        .Branch(Branch0), .illegal_op(ill0), .state_o(st0)
    );

    main_control_fsm #(.MEM_LAT(2)) dut2 (
        .clk(clk), .rst(rst2), .opcode(opc2), .funct(fn2),
        .IorD(IorD2), .MemWrite(MemWrite2), .IRWrite(IRWrite2), .RegDst(RegDst2),
        .MemtoReg(MemtoReg2), .RegWrite(RegWrite2), .ALUSrcA(ALUSrcA2),
        .ALUSrcB(ALUSrcB2), .ALUop(ALUop2), .PCSrc(PCSrc2), .PCWrite(PCWrite2),
        .Branch(Branch2), .illegal_op(ill2), .state_o(st2)
    );

    // Observed bundle: {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
    //                   ALUSrcA, ALUSrcB[1:0], ALUop[1:0], PCSrc[1:0], PCWrite, Branch}
    logic [14:0] ov [2];
    logic [3:0]  os [2];
    logic        oi [2];
    always_comb begin
        ov[0] = {IorD0, MemWrite0, IRWrite0, RegDst0, MemtoReg0, RegWrite0, ALUSrcA0,
                 ALUSrcB0, ALUop0, PCSrc0, PCWrite0, Branch0};
        ov[1] = {IorD2, MemWrite2, IRWrite2, RegDst2, MemtoReg2, RegWrite2, ALUSrcA2,
                 ALUSrcB2, ALUop2, PCSrc2, PCWrite2, Branch2};
        os[0] = st0;
        os[1] = st2;
        oi[0] = ill0;
        oi[1] = ill2;
    end

    int total = 0;
    int bad   = 0;

    int p_st[$];
    bit p_fin[$];

    logic [5:0] ops [10];
    logic [5:0] fns [11];

    function automatic bit is_legal(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00)
            return fn inside {6'h00, 6'h02, 6'h03, 6'h08, 6'h20, 6'h22,
                              6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};
        return op inside {6'h23, 6'h2B, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h02};
    endfunction

    // Expected outputs for a state; fin marks the final (counter==0) cycle.
    function automatic logic [14:0] exp_outs(input int s, input bit fin);
        logic [14:0] v;
        v = '0;
        case (s)
            FETCH:    begin v[7:6] = 2'b01; v[12] = fin; v[1] = fin; end
            DECODE:   v[7:6] = 2'b11;
            MEMADR:   begin v[8] = 1'b1; v[7:6] = 2'b10; end
            MEMREAD:  v[14] = 1'b1;
            MEMWB:    begin v[10] = 1'b1; v[9] = fin; end
            MEMWRITE: begin v[14] = 1'b1; v[13] = fin; end
            EXECUTE:  begin v[8] = 1'b1; v[5:4] = 2'b10; end
            ALUWB:    begin v[11] = 1'b1; v[9] = fin; end
            BRANCH:   begin v[8] = 1'b1; v[5:4] = 2'b01; v[3:2] = 2'b01; v[0] = 1'b1; end
            IEXEC:    begin v[8] = 1'b1; v[7:6] = 2'b10; end
            IWB:      v[9] = fin;
            JUMP:     begin v[3:2] = 2'b10; v[1] = fin; end
            JR:       begin v[3:2] = 2'b11; v[1] = fin; end
            default:  v = '0;
        endcase
        return v;
    endfunction

    task automatic add(input int s, input int lat);
        int n;
        n = (s == FETCH || s == MEMREAD || s == MEMWRITE) ? lat : 0;
        for (int i = 0; i < n; i++) begin
            p_st.push_back(s);
            p_fin.push_back(1'b0);
        end
        p_st.push_back(s);
        p_fin.push_back(1'b1);
    endtask

    // Cycle-by-cycle path of one instruction, from the instruction-class rules.
    task automatic build(input int lat, input logic [5:0] op, input logic [5:0] fn);
        p_st.delete();
        p_fin.delete();
        add(FETCH, lat);
        add(DECODE, lat);
        if (!is_legal(op, fn)) begin
        end else if (op == 6'h23) begin
            add(MEMADR, lat); add(MEMREAD, lat); add(MEMWB, lat);
        end else if (op == 6'h2B) begin
            add(MEMADR, lat); add(MEMWRITE, lat);
        end else if (op == 6'h00) begin
            if (fn == 6'h08) add(JR, lat);
            else begin add(EXECUTE, lat); add(ALUWB, lat); end
        end else if (op == 6'h04) begin
            add(BRANCH, lat);
        end else if (op == 6'h02) begin
            add(JUMP, lat);
        end else begin
            add(IEXEC, lat); add(IWB, lat);
        end
    endtask

    task automatic check(input int d, input string tag, input int s,
                         input logic [14:0] ev, input logic ei);
        total++;
        assert (os[d] === 4'(s)) else begin
            bad++;
            $error("FAIL %s state got=%0d exp=%0d", tag, os[d], s);
        end
        total++;
        assert (ov[d] === ev) else begin
            bad++;
            $error("FAIL %s outs got=%b exp=%b", tag, ov[d], ev);
        end
        total++;
        assert (oi[d] === ei) else begin
            bad++;
            $error("FAIL %s illegal_op got=%b exp=%b", tag, oi[d], ei);
        end
        total++;
        assert (($countones({ov[d][13], ov[d][12], ov[d][9]}) <= 1) && !(ov[d][1] && ov[d][0])) else begin
            bad++;
            $error("FAIL %s invariant got=%b exp=exclusive_enables", tag, ov[d]);
        end
    endtask

    // Runs one instruction; limit >= 0 stops after that many cycles.
    task automatic run_instr(input int d, input string name, input logic [5:0] op,
                             input logic [5:0] fn, input int limit);
        build((d == 0) ? 0 : 2, op, fn);
        for (int c = 0; c < p_st.size() && (limit < 0 || c < limit); c++) begin
            @(negedge clk);
            if (c == 0) begin
                if (d == 0) begin rst0 = 1'b0; opc0 = op; fn0 = fn; end
                else        begin rst2 = 1'b0; opc2 = op; fn2 = fn; end
            end
            #1;
            check(d, $sformatf("d%0d_%s_c%0d", d, name, c), p_st[c],
                  exp_outs(p_st[c], p_fin[c]),
                  (p_st[c] == DECODE) && !is_legal(op, fn));
        end
    endtask

    task automatic do_reset(input int d);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (d == 0) rst0 = 1'b1; else rst2 = 1'b1;
            #1;
            total++;
            assert ({ov[d][13], ov[d][12], ov[d][9], ov[d][1], oi[d]} === 5'b0) else begin
                bad++;
                $error("FAIL d%0d_rst_c%0d enables got=%b exp=00000", d, c,
                       {ov[d][13], ov[d][12], ov[d][9], ov[d][1], oi[d]});
            end
            if (c > 0) begin
                total++;
                assert (os[d] === 4'(FETCH)) else begin
                    bad++;
                    $error("FAIL d%0d_rst_c%0d state got=%0d exp=%0d", d, c, os[d], FETCH);
                end
            end
        end
    endtask

    task automatic run_random(input int d, input int n);
        logic [5:0] op, fn;
        for (int i = 0; i < n; i++) begin
            op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
            fn = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fns[$urandom_range(0, 10)];
            run_instr(d, $sformatf("rnd%0d", i), op, fn, -1);
        end
    endtask

    initial begin
        rst0 = 1'b1; rst2 = 1'b1;
        opc0 = '0; fn0 = '0; opc2 = '0; fn2 = '0;
        ops = '{6'h00, 6'h02, 6'h04, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B};
        fns = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};

        // MEM_LAT = 0 instance
        do_reset(0);
        run_instr(0, "lw",    6'h23, 6'h00, -1);
        run_instr(0, "jr",    6'h00, 6'h08, -1);
        run_instr(0, "add",   6'h00, 6'h20, -1);
        run_instr(0, "beq",   6'h04, 6'h00, -1);
        run_instr(0, "ori",   6'h0D, 6'h00, -1);
        run_instr(0, "j",     6'h02, 6'h00, -1);
        run_instr(0, "sw",    6'h2B, 6'h00, -1);
        run_instr(0, "ill3f", 6'h3F, 6'h00, -1);
        run_instr(0, "illfn", 6'h00, 6'h01, -1);
        run_instr(0, "slti",  6'h0A, 6'h00, -1);
        run_random(0, 40);

        @(negedge clk);
        rst0 = 1'b1;

        // MEM_LAT = 2 instance
        do_reset(1);
        run_instr(1, "sw",    6'h2B, 6'h00, -1);
        run_instr(1, "lw",    6'h23, 6'h00, -1);
        run_instr(1, "ill3f", 6'h3F, 6'h00, -1);
        // Stop in the first MEMREAD wait cycle and reset there.
        run_instr(1, "lw_cut", 6'h23, 6'h00, 6);
        @(negedge clk);
        rst2 = 1'b1;
        #1;
        check(1, "midwait_rst", MEMREAD, exp_outs(MEMREAD, 1'b0), 1'b0);
        run_instr(1, "after_rst_j", 6'h02, 6'h00, -1);
        run_random(1, 30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
